systolic_ctrl: RTL and testbench

Sequencing controller for the N×N systolic matrix-multiply array built from the FP8-input, BF16-accumulate PEs. Each PE runs a 3-stage pipeline and has a broadcast `clear`. On `start`, this block flushes and zeroes the accumulators, then emits the skewed per-lane feed schedule for a K-deep inner product. It waits for the PE pipelines to drain and pulses `done` when every PE `c_out` holds its final result. The A-row and B-column edge buffers sit beside it and are driven from its lane outputs.

---
 rtl/systolic_ctrl.sv | 165 ++++++++++++++++
 tb/tb_systolic_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// Sequencing controller for an NxN systolic matmul array: flushes the PEs, emits the
// skewed per-lane A/B feed schedule for a K-deep product, waits out the drain, pulses done.
module systolic_ctrl #(
    parameter int N        = 2,
    parameter int K_MAX    = 16,
    parameter int PIPE_LAT = 3,
    parameter int KW       = $clog2(K_MAX + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            abort,
    output logic            clear,
    output logic [N-1:0]    lane_valid,
    output logic [N*KW-1:0] lane_k,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam int C_LEN = 2 * N - 2 + PIPE_LAT;
    localparam int D_LEN = N + PIPE_LAT - 2;
    localparam int F_MAX = K_MAX + N - 1;
    localparam int M1    = (C_LEN > D_LEN) ? C_LEN : D_LEN;
    localparam int M2    = (M1 > F_MAX) ? M1 : F_MAX;
    localparam int CW    = $clog2(M2 + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t            state_reg;
    logic [CW-1:0]     cnt_reg;
    logic [KW-1:0]     k_reg;
    logic              clear_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic [N-1:0]      lane_valid_reg;
    logic [N*KW-1:0]   lane_k_reg;

    logic [CW:0]       step_next;
    logic [CW:0]       feed_end;
    logic [N-1:0]      lane_valid_next;
    logic [N*KW-1:0]   lane_k_next;

    // Step index the lanes will present next cycle; 0 when FEED is about to be entered.
    assign step_next = (state_reg == FEED) ? ({1'b0, cnt_reg} + (CW+1)'(1)) : '0;
    assign feed_end  = (CW+1)'(k_reg) + (CW+1)'(N - 1) - (CW+1)'(1);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            localparam logic [CW:0] IDX = (CW+1)'(gi);
            logic [CW:0] rel;
            assign rel = step_next - IDX;
            assign lane_valid_next[gi] = (step_next >= IDX) && (rel < (CW+1)'(k_reg));
            assign lane_k_next[gi*KW +: KW] = lane_valid_next[gi] ? rel[KW-1:0] : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            k_reg          <= '0;
            clear_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            lane_valid_reg <= '0;
            lane_k_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        if ({1'b0, k_len} <= (KW+1)'(K_MAX)) begin
                            k_reg     <= k_len;
                            cnt_reg   <= '0;
                            clear_reg <= 1'b1;
                            busy_reg  <= 1'b1;
                            state_reg <= CLEAR;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        clear_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CW'(C_LEN - 1)) begin
                        clear_reg <= 1'b0;
                        cnt_reg   <= '0;
                        if (k_reg == '0) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            lane_valid_reg <= lane_valid_next;
                            lane_k_reg     <= lane_k_next;
                            state_reg      <= FEED;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                FEED: begin
                    if (abort) begin
                        state_reg      <= IDLE;
                        busy_reg       <= 1'b0;
                        cnt_reg        <= '0;
                        lane_valid_reg <= '0;
                        lane_k_reg     <= '0;
                    end else if ({1'b0, cnt_reg} == feed_end) begin
                        lane_valid_reg <= '0;
                        lane_k_reg     <= '0;
                        cnt_reg        <= '0;
                        if (D_LEN == 0) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= DRAIN;
                        end
                    end else begin
                        cnt_reg        <= cnt_reg + CW'(1);
                        lane_valid_reg <= lane_valid_next;
                        lane_k_reg     <= lane_k_next;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CW'(D_LEN - 1)) begin
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign clear      = clear_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign lane_valid = lane_valid_reg;
    assign lane_k     = lane_k_reg;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: each job's full output timeline is compared every cycle
// against a timing model built from the job's cycle-by-cycle schedule formulas.
module tb_systolic_ctrl;
    localparam int N        = 2;
    localparam int K_MAX    = 16;
    localparam int PIPE_LAT = 3;
    localparam int KW       = $clog2(K_MAX + 1);
    localparam int C_LEN    = 2 * N - 2 + PIPE_LAT;
    localparam int D_LEN    = N + PIPE_LAT - 2;
    localparam int VW       = 4 + N + N * KW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic            abort = 1'b0;
    logic            clear;
    logic [N-1:0]    lane_valid;
    logic [N*KW-1:0] lane_k;
    logic            busy;
    logic            done;
    logic            err;

    int checks = 0;
    int fails  = 0;
    int passed;

    systolic_ctrl #(.N(N), .K_MAX(K_MAX), .PIPE_LAT(PIPE_LAT), .KW(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
        .clear(clear), .lane_valid(lane_valid), .lane_k(lane_k),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int done_cycle(input int K);
        return (K == 0) ? C_LEN + 1 : C_LEN + K + N - 1 + D_LEN + 1;
    endfunction

    // Expected {clear,busy,done,err,lane_valid,lane_k} in cycle t of a job started in cycle 0.
    // ab: cycle where abort/reset is applied (-1 = never, 0 = together with start).
    function automatic logic [VW-1:0] model(input int t, input int K, input int ab);
        logic clr, bsy, dn, er;
        logic [N-1:0] lv;
        logic [N*KW-1:0] lk;
        int td, s;
        clr = 0; bsy = 0; dn = 0; er = 0; lv = '0; lk = '0;
        if (K > K_MAX) begin
            er = (t == 1);
        end else if (ab == 0 || (ab > 0 && t > ab)) begin
            er = 0;
        end else begin
            td  = done_cycle(K);
            clr = (t >= 1 && t <= C_LEN);
            bsy = (t >= 1 && t < td);
            dn  = (t == td);
            s   = t - (C_LEN + 1);
            if (K > 0 && s >= 0 && s <= K + N - 2) begin
                for (int i = 0; i < N; i++) begin
                    if (s >= i && s - i < K) begin
                        lv[i] = 1'b1;
                        lk[i*KW +: KW] = KW'(s - i);
                    end
                end
            end
        end
        return {clr, bsy, dn, er, lv, lk};
    endfunction

    function automatic logic [VW-1:0] observed();
        return {clear, busy, done, err, lane_valid, lane_k};
    endfunction

    // One job: start at cycle 0, optional abort/reset at cycle ab, optional extra start at sb.
    task automatic run_job(input string tag, input int K, input int ab, input int use_rst,
                           input int sb);
        int tend;
        int job_fails;
        logic [VW-1:0] exp_v, obs_v;
        job_fails = fails;
        tend = (K > K_MAX) ? 3 : done_cycle(K) + 2;
        for (int t = 0; t <= tend; t++) begin
            start = (t == 0) || (t == sb);
            k_len = (t == 0) ? KW'(K) : KW'($urandom_range(0, K_MAX));
            abort = (t == ab) && (use_rst == 0);
            rst   = (t == ab) && (use_rst != 0);
            @(negedge clk);
            exp_v = model(t, K, ab);
            obs_v = observed();
            checks++;
            assert (obs_v === exp_v) else begin
                fails++;
                $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs_v, exp_v);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        $display("job %s K=%0d ab=%0d rst=%0d sb=%0d cycles=%0d fails=%0d",
                 tag, K, ab, use_rst, sb, tend + 1, fails - job_fails);
    endtask

    initial begin
        int K, ab, sb, mode;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        assert (observed() === '0) else begin
            fails++;
            $error("FAIL reset observed=%h expected=%h", observed(), {VW{1'b0}});
        end
        @(posedge clk);
        #1;

        run_job("nominal",        4,  -1, 0, -1);
        run_job("k_zero",         0,  -1, 0, -1);
        run_job("reject",         17, -1, 0, -1);
        run_job("abort_feed",     4,   8, 0, -1);
        run_job("after_abort",    4,  -1, 0, -1);
        run_job("start_busy",     4,  -1, 0,  7);
        run_job("start_abort",    4,   0, 0, -1);
        run_job("reset_drain",    4,  12, 1, -1);
        run_job("after_reset",    4,  -1, 0, -1);
        run_job("k_max",          K_MAX, -1, 0, -1);

        for (int j = 0; j < 24; j++) begin
            mode = $urandom_range(0, 4);
            K    = $urandom_range(0, K_MAX);
            ab   = -1;
            sb   = -1;
            if (mode == 0) begin
                K = $urandom_range(K_MAX + 1, (1 << KW) - 1);
            end else if (mode == 1 || mode == 2) begin
                ab = $urandom_range(1, done_cycle(K));
            end else if (mode == 3) begin
                sb = $urandom_range(1, done_cycle(K));
            end
            run_job($sformatf("rand%0d", j), K, ab, (mode == 2) ? 1 : 0, sb);
        end

        passed = checks - fails;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
